// File: rtl/folded_hidden_layer.sv
// folded_hidden_layer: time-multiplexed hidden layer (MAC, bias, shift/saturate, ReLU) over NL reused lanes
module folded_hidden_layer #(
  parameter int NP = 8,
  parameter int NC = 7,
  parameter int NL = 2,
  parameter int WF = 16,
  parameter int FB = 8,
  parameter string BURST = "yes"
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iMode,
  input  logic                        iValid_AM_State0,
  output logic                        oReady_AM_State0,
  input  logic [NP*WF-1:0]            iData_AM_State0,
  input  logic                        iValid_AM_WeightBias,
  output logic                        oReady_AM_WeightBias,
  input  logic [NL*NP*WF+NL*WF-1:0]   iData_AM_WeightBias,
  output logic                        oValid_BM_State0,
  input  logic                        iReady_BM_State0,
  output logic [NC*WF-1:0]            oData_BM_State0,
  output logic                        oValid_BM_State1,
  input  logic                        iReady_BM_State1,
  output logic [NC*WF-1:0]            oData_BM_State1
);
  localparam int NG = (NC + NL - 1) / NL;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int AW = 2 * WF + $clog2(NP + 1);
  localparam bit BY = (BURST == "yes");
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t state, next;
  logic [GW-1:0] grp;
  logic [NP*WF-1:0] x;
  logic mode;
  logic signed [AW-1:0] acc [NL];
  logic signed [AW-1:0] sh [NL];
  logic signed [WF-1:0] pre [NL];
  logic signed [WF-1:0] act [NL];
  logic s0_hs, wb_hs, done, last_grp;
  assign last_grp = grp == GW'(NG - 1);
  assign done = (!oValid_BM_State0 || iReady_BM_State0) && (!oValid_BM_State1 || iReady_BM_State1);
  assign oReady_AM_State0 = !iRST && (state == IDLE || (BY && state == OUT && done));
  assign oReady_AM_WeightBias = !iRST && state == RUN;
  assign s0_hs = iValid_AM_State0 && oReady_AM_State0;
  assign wb_hs = iValid_AM_WeightBias && oReady_AM_WeightBias;
  // per-lane full-precision MAC with bias, then shift, saturate and ReLU
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      acc[l] = AW'($signed(iData_AM_WeightBias[NL*NP*WF + l*WF +: WF])) <<< FB;
      for (int i = 0; i < NP; i++)
        acc[l] = acc[l] + AW'($signed(iData_AM_WeightBias[(l*NP+i)*WF +: WF])) * AW'($signed(x[i*WF +: WF]));
      sh[l] = acc[l] >>> FB;
      pre[l] = (&sh[l][AW-1:WF-1] || ~|sh[l][AW-1:WF-1]) ? sh[l][WF-1:0] : {sh[l][AW-1], {(WF-1){~sh[l][AW-1]}}};
      act[l] = pre[l][WF-1] ? '0 : pre[l];
    end
  end
  // next state; a burst accept in OUT jumps straight back to RUN
  always_comb begin
    next = state;
    case (state)
      IDLE: next = s0_hs ? RUN : IDLE;
      RUN:  next = (wb_hs && last_grp) ? OUT : RUN;
      default: next = done ? (s0_hs ? RUN : IDLE) : OUT;
    endcase
  end
  // state register
  always_ff @(posedge iCLK) state <= iRST ? IDLE : next;
  // input capture, group results and output valids
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      grp <= '0;
      mode <= 1'b0;
      x <= '0;
      oValid_BM_State0 <= 1'b0;
      oValid_BM_State1 <= 1'b0;
      oData_BM_State0 <= '0;
      oData_BM_State1 <= '0;
    end else begin
      if (oValid_BM_State0 && iReady_BM_State0) oValid_BM_State0 <= 1'b0;
      if (oValid_BM_State1 && iReady_BM_State1) oValid_BM_State1 <= 1'b0;
      if (s0_hs) begin
        x <= iData_AM_State0;
        mode <= iMode;
        grp <= '0;
      end
      if (wb_hs) begin
        for (int l = 0; l < NL; l++)
          if (int'(grp) * NL + l < NC) begin
            oData_BM_State0[(int'(grp)*NL+l)*WF +: WF] <= act[l];
            oData_BM_State1[(int'(grp)*NL+l)*WF +: WF] <= pre[l];
          end
        grp <= grp + 1'b1;
        if (last_grp) begin
          oValid_BM_State0 <= 1'b1;
          oValid_BM_State1 <= mode;
        end
      end
    end
  end
endmodule

// File: tb/tb_folded_hidden_layer.sv
// tb_folded_hidden_layer: directed checks of the folded hidden layer (NP=2, NC=3, NL=2)
module tb_folded_hidden_layer;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, vs0 = 1'b0, vwb = 1'b0, rb0 = 1'b0, rb1 = 1'b0;
  logic [31:0] ds0 = '0;
  logic [95:0] dwb = '0;
  logic rs0, rwb, vb0, vb1, nrs0, nrwb, nvb0, nvb1;
  logic [47:0] db0, db1, ndb0, ndb1;
  int checks = 0, errors = 0, k;
  localparam logic [31:0] X1 = {16'h0200, 16'h0100};
  localparam logic [95:0] WB0 = {16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h0100, 16'h0100};
  localparam logic [95:0] WB1 = {16'h1234, 16'h0100, 16'h1234, 16'h1234, 16'h0080, 16'h0080};
  localparam logic [47:0] Y0 = {16'h0280, 16'h0000, 16'h0300};
  localparam logic [47:0] Y1 = {16'h0280, 16'hFF00, 16'h0300};
  localparam logic [31:0] XS = {16'h7FFF, 16'h7FFF};
  localparam logic [95:0] WBS0 = {16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
  localparam logic [47:0] YS0 = {16'h0000, 16'h0000, 16'h7FFF};
  localparam logic [47:0] YS1 = {16'h0000, 16'h8000, 16'h7FFF};

  folded_hidden_layer #(.NP(2), .NC(3), .NL(2), .WF(16), .FB(8), .BURST("yes")) dut (
    .iCLK(clk), .iRST(rst), .iMode(mode),
    .iValid_AM_State0(vs0), .oReady_AM_State0(rs0), .iData_AM_State0(ds0),
    .iValid_AM_WeightBias(vwb), .oReady_AM_WeightBias(rwb), .iData_AM_WeightBias(dwb),
    .oValid_BM_State0(vb0), .iReady_BM_State0(rb0), .oData_BM_State0(db0),
    .oValid_BM_State1(vb1), .iReady_BM_State1(rb1), .oData_BM_State1(db1));

  folded_hidden_layer #(.NP(2), .NC(3), .NL(2), .WF(16), .FB(8), .BURST("no")) dut_n (
    .iCLK(clk), .iRST(rst), .iMode(1'b0),
    .iValid_AM_State0(1'b1), .oReady_AM_State0(nrs0), .iData_AM_State0(ds0),
    .iValid_AM_WeightBias(1'b1), .oReady_AM_WeightBias(nrwb), .iData_AM_WeightBias(dwb),
    .oValid_BM_State0(nvb0), .iReady_BM_State0(1'b1), .oData_BM_State0(ndb0),
    .oValid_BM_State1(nvb1), .iReady_BM_State1(1'b1), .oData_BM_State1(ndb1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_rdy_s0", 64'(rs0), 0);
    chk("rst_rdy_wb", 64'(rwb), 0);
    chk("rst_valid", 64'({vb0, vb1}), 0);
    chk("rst_data", 64'(db0 | db1), 0);
    rst = 1'b0;
    tick;
    chk("idle_rdy", 64'(rs0), 1);
    // training-mode vector
    ds0 = X1; mode = 1'b1; vs0 = 1'b1;
    tick;
    vs0 = 1'b0; mode = 1'b0; vwb = 1'b1; dwb = WB0;
    #1;
    chk("run_rdy_wb", 64'(rwb), 1);
    chk("run_rdy_s0", 64'(rs0), 0);
    tick;
    dwb = WB1;
    chk("lat_early", 64'(vb0), 0);
    tick;
    vwb = 1'b0;
    chk("lat_valid0", 64'(vb0), 1);
    chk("valid1_train", 64'(vb1), 1);
    chk("y0", 64'(db0), 64'(Y0));
    chk("y1", 64'(db1), 64'(Y1));
    rb0 = 1'b1;
    tick;
    rb0 = 1'b0;
    chk("v0_drop", 64'(vb0), 0);
    repeat (4) tick;
    chk("hold_v1", 64'(vb1), 1);
    chk("hold_y1", 64'(db1), 64'(Y1));
    chk("hold_rdy", 64'(rs0), 0);
    rb1 = 1'b1;
    #1;
    chk("burst_rdy", 64'(rs0), 1);
    tick;
    rb1 = 1'b0;
    chk("idle_valid", 64'({vb0, vb1}), 0);
    chk("idle_rdy2", 64'(rs0), 1);
    // inference mode, then a back-to-back training vector
    ds0 = X1; mode = 1'b0; vs0 = 1'b1;
    tick;
    vs0 = 1'b0; vwb = 1'b1; dwb = WB0;
    tick;
    dwb = WB1;
    tick;
    vwb = 1'b0;
    chk("m0_v0", 64'(vb0), 1);
    chk("m0_v1", 64'(vb1), 0);
    chk("m0_y0", 64'(db0), 64'(Y0));
    rb0 = 1'b1; vs0 = 1'b1; ds0 = XS; mode = 1'b1;
    #1;
    chk("b2b_rdy", 64'(rs0), 1);
    tick;
    rb0 = 1'b0; vs0 = 1'b0; mode = 1'b0;
    chk("m0_done", 64'(vb0), 0);
    vwb = 1'b1; dwb = WBS0;
    tick;
    dwb = '0;
    chk("b2b_early", 64'(vb0), 0);
    tick;
    vwb = 1'b0;
    chk("b2b_v0", 64'(vb0), 1);
    chk("b2b_v1", 64'(vb1), 1);
    chk("sat_act", 64'(db0), 64'(YS0));
    chk("sat_pre", 64'(db1), 64'(YS1));
    rb0 = 1'b1; rb1 = 1'b1;
    tick;
    rb0 = 1'b0; rb1 = 1'b0;
    chk("sat_idle", 64'(rs0), 1);
    // weight/bias valid gaps 1,0,0,1
    ds0 = X1; vs0 = 1'b1;
    tick;
    vs0 = 1'b0; vwb = 1'b1; dwb = WB0;
    tick;
    vwb = 1'b0; dwb = WB1;
    tick;
    tick;
    vwb = 1'b1;
    chk("gap_early", 64'(vb0), 0);
    tick;
    vwb = 1'b0;
    chk("gap_v0", 64'(vb0), 1);
    chk("gap_y0", 64'(db0), 64'(Y0));
    rb0 = 1'b1;
    tick;
    rb0 = 1'b0;
    // reset after group 0
    ds0 = X1; mode = 1'b1; vs0 = 1'b1;
    tick;
    vs0 = 1'b0; mode = 1'b0; vwb = 1'b1; dwb = WB0;
    tick;
    vwb = 1'b0; rst = 1'b1;
    #1;
    chk("rst_run_rdy", 64'(rs0), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", 64'(rs0), 1);
    tick;
    tick;
    chk("rst_no_valid", 64'({vb0, vb1}), 0);
    chk("rst_no_data", 64'(db0), 0);
    ds0 = X1; vs0 = 1'b1;
    tick;
    vs0 = 1'b0; vwb = 1'b1; dwb = WB0;
    tick;
    dwb = WB1;
    tick;
    vwb = 1'b0;
    chk("post_rst_v0", 64'(vb0), 1);
    chk("post_rst_y0", 64'(db0), 64'(Y0));
    rb0 = 1'b1;
    tick;
    rb0 = 1'b0;
    // no-burst instance free-runs; its output period includes one IDLE cycle
    k = 0;
    while (!nvb0 && k < 20) begin
      tick;
      k++;
    end
    chk("nb_found", 64'(nvb0), 1);
    chk("nb_no_burst_rdy", 64'(nrs0), 0);
    tick;
    k = 1;
    while (!nvb0 && k < 20) begin
      tick;
      k++;
    end
    chk("nb_period", 64'(k), 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
